// File: rtl/acc_stream_checker.sv
// Checks core output beats against a buffered expected stream; status lags a compare by one cycle.
// Core output is throttled by an LFSR ready pattern; the expected side stalls only when the FIFO is full.
module acc_stream_checker #(
    parameter int          DATA_W    = 128,
    parameter int          DEPTH     = 16,
    parameter int          CNT_W     = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clk_core,
    input  logic                rst_core,
    input  logic                clr,
    input  logic [1:0]          bp_mode,
    input  logic                stop_on_error,
    input  logic [DATA_W-1:0]   exp_tdata,
    input  logic                exp_tvalid,
    output logic                exp_tready,
    input  logic [DATA_W-1:0]   dut_tdata,
    input  logic                dut_tvalid,
    output logic                dut_tready,
    output logic [CNT_W-1:0]    beat_cnt,
    output logic [CNT_W-1:0]    err_cnt,
    output logic                err_flag,
    output logic                halted,
    output logic [CNT_W-1:0]    first_err_idx,
    output logic [DATA_W-1:0]   first_err_got,
    output logic [DATA_W-1:0]   first_err_exp,
    output logic [DATA_W/8-1:0] first_err_mask
);

    localparam int AW = $clog2(DEPTH);
    localparam int NB = DATA_W / 8;

    typedef enum logic {RUN, HALT} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              mismatch;
    logic [DATA_W-1:0] head;
    logic [NB-1:0]     byte_mask;
    logic [15:0]       lfsr;
    logic              lfsr_fb;
    logic              bp_rdy;
    logic              bp_nxt;
    state_t            state;
    state_t            state_nxt;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    assign exp_tready = !full;
    assign dut_tready = bp_rdy && !empty && (state == RUN);
    assign push       = exp_tvalid && !full && !clr;
    assign pop        = dut_tvalid && dut_tready && !clr;

    always_comb begin
        byte_mask = '0;
        for (int i = 0; i < NB; i++) begin
            byte_mask[i] = |(dut_tdata[8*i +: 8] ^ head[8*i +: 8]);
        end
    end

    assign mismatch = |byte_mask;
    assign halted   = (state == HALT);
    assign err_flag = (err_cnt != '0);

    always_ff @(posedge clk_core) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= exp_tdata;
        end
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Fibonacci LFSR, taps 16,14,13,11.
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_comb begin
        bp_nxt = 1'b0;
        unique case (bp_mode)
            2'd0: bp_nxt = 1'b1;
            2'd1: bp_nxt = (lfsr[1:0] != 2'b00);
            2'd2: bp_nxt = lfsr[0];
            2'd3: bp_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            lfsr   <= LFSR_SEED;
            bp_rdy <= 1'b0;
        end else if (clr) begin
            lfsr   <= LFSR_SEED;
            bp_rdy <= 1'b0;
        end else begin
            lfsr   <= {lfsr[14:0], lfsr_fb};
            bp_rdy <= bp_nxt;
        end
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            state <= RUN;
        end else if (clr) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // HALT is left only through clr or reset.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:  if (pop && mismatch && stop_on_error) state_nxt = HALT;
            HALT: state_nxt = HALT;
        endcase
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            beat_cnt       <= '0;
            err_cnt        <= '0;
            first_err_idx  <= '0;
            first_err_got  <= '0;
            first_err_exp  <= '0;
            first_err_mask <= '0;
        end else if (clr) begin
            beat_cnt       <= '0;
            err_cnt        <= '0;
            first_err_idx  <= '0;
            first_err_got  <= '0;
            first_err_exp  <= '0;
            first_err_mask <= '0;
        end else if (pop) begin
            if (beat_cnt != '1) beat_cnt <= beat_cnt + CNT_W'(1);
            if (mismatch) begin
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                // Only the very first mismatch since clear is captured.
                if (err_cnt == '0) begin
                    first_err_idx  <= beat_cnt;
                    first_err_got  <= dut_tdata;
                    first_err_exp  <= head;
                    first_err_mask <= byte_mask;
                end
            end
        end
    end

endmodule

// File: tb/tb_acc_stream_checker.sv
module tb_acc_stream_checker;

    localparam logic [15:0] SEED = 16'hACE1;

    logic         clk_core = 1'b0;
    logic         rst_core;
    logic         clr;
    logic [1:0]   bp_mode;
    logic         stop_on_error;
    logic [127:0] exp_tdata;
    logic         exp_tvalid;
    logic         exp_tready;
    logic [127:0] dut_tdata;
    logic         dut_tvalid;
    logic         dut_tready;
    logic [31:0]  beat_cnt;
    logic [31:0]  err_cnt;
    logic         err_flag;
    logic         halted;
    logic [31:0]  first_err_idx;
    logic [127:0] first_err_got;
    logic [127:0] first_err_exp;
    logic [15:0]  first_err_mask;

    acc_stream_checker #(
        .DATA_W(128), .DEPTH(16), .CNT_W(32), .LFSR_SEED(SEED)
    ) dut (
        .clk_core(clk_core), .rst_core(rst_core), .clr(clr),
        .bp_mode(bp_mode), .stop_on_error(stop_on_error),
        .exp_tdata(exp_tdata), .exp_tvalid(exp_tvalid), .exp_tready(exp_tready),
        .dut_tdata(dut_tdata), .dut_tvalid(dut_tvalid), .dut_tready(dut_tready),
        .beat_cnt(beat_cnt), .err_cnt(err_cnt), .err_flag(err_flag), .halted(halted),
        .first_err_idx(first_err_idx), .first_err_got(first_err_got),
        .first_err_exp(first_err_exp), .first_err_mask(first_err_mask)
    );

    always #5 clk_core = ~clk_core;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          n;
        int          err_a;
        int          err_b;
        int          err_byte;
        bit          stop;
        int          beats;
        int          errs;
        int          idx;
        logic [15:0] mask;
        bit          halt;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic do_clr();
        clr        = 1'b1;
        exp_tvalid = 1'b0;
        dut_tvalid = 1'b0;
        tick();
        clr = 1'b0;
    endtask

    function automatic logic [127:0] beat(input int i);
        logic [127:0] b;
        b = 128'h0F0E0D0C0B0A09080706050403020100;
        return b + 128'(i);
    endfunction

    function automatic logic [127:0] corrupt(input vec_t v, input int k);
        logic [127:0] d;
        d = beat(k);
        if (k == v.err_a || k == v.err_b) d[8*v.err_byte +: 8] = d[8*v.err_byte +: 8] ^ 8'hFF;
        return d;
    endfunction

    function automatic logic bp_of(input logic [1:0] m, input logic [15:0] l);
        case (m)
            2'd0:    return 1'b1;
            2'd1:    return l[1:0] != 2'b00;
            2'd2:    return l[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic push_beats(input int n);
        for (int i = 0; i < n; i++) begin
            exp_tvalid = 1'b1;
            exp_tdata  = beat(i);
            tick();
            if (i == 0) check("first_push_tready", 128'(dut_tready), 128'(1));
        end
        exp_tvalid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        int cyc;
        logic rdy;
        logic [127:0] eg;
        logic [127:0] ee;
        bp_mode       = 2'd0;
        stop_on_error = v.stop;
        do_clr();
        check("idle_tready", 128'(dut_tready), 128'(0));
        push_beats(v.n);
        k   = 0;
        cyc = 0;
        while (k < v.n && !halted && cyc < 64) begin
            dut_tvalid = 1'b1;
            dut_tdata  = corrupt(v, k);
            rdy        = dut_tready;
            tick();
            if (rdy) k++;
            cyc++;
        end
        check("stream_done", 128'((k == v.n) || halted), 128'(1));
        tick();
        check("beat_cnt", 128'(beat_cnt), 128'(v.beats));
        check("err_cnt", 128'(err_cnt), 128'(v.errs));
        check("err_flag", 128'(err_flag), 128'(v.errs != 0));
        check("halted", 128'(halted), 128'(v.halt));
        check("first_err_idx", 128'(first_err_idx), 128'(v.idx));
        check("first_err_mask", 128'(first_err_mask), 128'(v.mask));
        eg = (v.err_a >= 0) ? corrupt(v, v.err_a) : 128'd0;
        ee = (v.err_a >= 0) ? beat(v.err_a) : 128'd0;
        check("first_err_got", first_err_got, eg);
        check("first_err_exp", first_err_exp, ee);
        check("tready_after", 128'(dut_tready), 128'(0));
        dut_tvalid = 1'b0;
        if (v.halt) begin
            stop_on_error = 1'b0;
            tick();
            tick();
            check("halt_sticky", 128'(halted), 128'(1));
            check("halt_no_compare", 128'(beat_cnt), 128'(v.beats));
            do_clr();
            check("clr_halted", 128'(halted), 128'(0));
            check("clr_beat_cnt", 128'(beat_cnt), 128'(0));
            check("clr_err_cnt", 128'(err_cnt), 128'(0));
            check("clr_err_flag", 128'(err_flag), 128'(0));
            check("clr_idx", 128'(first_err_idx), 128'(0));
            check("clr_mask", 128'(first_err_mask), 128'(0));
            check("clr_got", first_err_got, 128'd0);
            check("clr_empty_tready", 128'(dut_tready), 128'(0));
        end
    endtask

    task automatic run_rand(input logic [1:0] m);
        logic [15:0] ml;
        logic        mb;
        int          pi;
        int          k;
        int          bad;
        int          cyc;
        logic        psh;
        logic        pp;
        bp_mode       = m;
        stop_on_error = 1'b0;
        do_clr();
        ml  = SEED;
        mb  = 1'b0;
        pi  = 0;
        k   = 0;
        bad = 0;
        cyc = 0;
        while (k < 256 && cyc < 2000) begin
            exp_tvalid = (pi < 256);
            exp_tdata  = beat(pi);
            dut_tvalid = 1'b1;
            dut_tdata  = beat(k);
            if (dut_tready !== (mb && (pi - k) > 0)) bad++;
            if (exp_tready !== ((pi - k) < 16)) bad++;
            psh = exp_tvalid && exp_tready;
            pp  = dut_tready;
            tick();
            pi += int'(psh);
            k  += int'(pp);
            mb  = bp_of(m, ml);
            ml  = lfsr_step(ml);
            cyc++;
        end
        exp_tvalid = 1'b0;
        dut_tvalid = 1'b0;
        check("rand_ready_pattern", 128'(bad), 128'(0));
        check("rand_done", 128'(k), 128'(256));
        check("rand_beat_cnt", 128'(beat_cnt), 128'(256));
        check("rand_err_cnt", 128'(err_cnt), 128'(0));
    endtask

    task automatic run_duty(input logic [1:0] m, input int lo, input int hi);
        logic [63:0] pat;
        logic [63:0] pat2;
        int          ones;
        pat  = '0;
        pat2 = '0;
        ones = 0;
        bp_mode = m;
        do_clr();
        exp_tvalid = 1'b1;
        exp_tdata  = beat(0);
        tick();
        exp_tvalid = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (i < 64) pat[i] = dut_tready;
            ones += int'(dut_tready);
            tick();
        end
        $display("[TB] mode %0d ready cycles %0d of 4000", m, ones);
        check("duty_window", 128'(ones >= lo && ones <= hi), 128'(1));
        do_clr();
        exp_tvalid = 1'b1;
        tick();
        exp_tvalid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            pat2[i] = dut_tready;
            tick();
        end
        check("duty_repeatable", 128'(pat2), 128'(pat));
    endtask

    initial begin
        int   k;
        int   cyc;
        logic rdy;

        rst_core      = 1'b1;
        clr           = 1'b0;
        bp_mode       = 2'd0;
        stop_on_error = 1'b0;
        exp_tdata     = '0;
        exp_tvalid    = 1'b0;
        dut_tdata     = '0;
        dut_tvalid    = 1'b0;

        //                n  err_a err_b byte stop beats errs idx mask      halt
        vecs[0] = '{n: 8,  err_a: -1, err_b: -1, err_byte: 0,  stop: 0, beats: 8,  errs: 0, idx: 0,  mask: 16'h0000, halt: 0};
        vecs[1] = '{n: 8,  err_a: 3,  err_b: -1, err_byte: 5,  stop: 0, beats: 8,  errs: 1, idx: 3,  mask: 16'h0020, halt: 0};
        vecs[2] = '{n: 8,  err_a: 2,  err_b: 4,  err_byte: 5,  stop: 1, beats: 3,  errs: 1, idx: 2,  mask: 16'h0020, halt: 1};
        vecs[3] = '{n: 8,  err_a: 1,  err_b: 6,  err_byte: 0,  stop: 0, beats: 8,  errs: 2, idx: 1,  mask: 16'h0001, halt: 0};
        vecs[4] = '{n: 16, err_a: 15, err_b: -1, err_byte: 15, stop: 1, beats: 16, errs: 1, idx: 15, mask: 16'h8000, halt: 1};

        #7;
        check("rst_exp_tready", 128'(exp_tready), 128'(1));
        check("rst_dut_tready", 128'(dut_tready), 128'(0));
        check("rst_beat_cnt", 128'(beat_cnt), 128'(0));
        check("rst_err_cnt", 128'(err_cnt), 128'(0));
        check("rst_err_flag", 128'(err_flag), 128'(0));
        check("rst_halted", 128'(halted), 128'(0));
        check("rst_idx", 128'(first_err_idx), 128'(0));
        check("rst_mask", 128'(first_err_mask), 128'(0));
        rst_core = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Fill to full while the core side is blocked, then release one pop.
        bp_mode       = 2'd3;
        stop_on_error = 1'b0;
        do_clr();
        for (int i = 0; i < 16; i++) begin
            exp_tvalid = 1'b1;
            exp_tdata  = beat(i);
            if (i == 15) check("full_pre_ready", 128'(exp_tready), 128'(1));
            tick();
        end
        check("full_ready_low", 128'(exp_tready), 128'(0));
        check("mode3_tready", 128'(dut_tready), 128'(0));
        exp_tdata  = beat(99);
        bp_mode    = 2'd0;
        dut_tvalid = 1'b1;
        dut_tdata  = beat(0);
        tick();
        check("full_pop_tready", 128'(dut_tready), 128'(1));
        check("full_pop_exp_rdy", 128'(exp_tready), 128'(0));
        tick();
        exp_tvalid = 1'b0;
        check("full_ready_rise", 128'(exp_tready), 128'(1));
        k   = 1;
        cyc = 0;
        while (k < 16 && cyc < 64) begin
            dut_tvalid = 1'b1;
            dut_tdata  = beat(k);
            rdy        = dut_tready;
            tick();
            if (rdy) k++;
            cyc++;
        end
        dut_tvalid = 1'b0;
        check("full_drained", 128'(k), 128'(16));
        check("full_beat_cnt", 128'(beat_cnt), 128'(16));
        check("full_err_cnt", 128'(err_cnt), 128'(0));
        tick();
        check("empty_tready", 128'(dut_tready), 128'(0));

        run_rand(2'd1);
        run_rand(2'd2);
        run_duty(2'd1, 2800, 3200);
        run_duty(2'd2, 1800, 2200);

        // Asynchronous reset between clock edges, mid-stream.
        bp_mode = 2'd0;
        do_clr();
        push_beats(8);
        k   = 0;
        cyc = 0;
        while (k < 5 && cyc < 64) begin
            dut_tvalid = 1'b1;
            dut_tdata  = beat(k);
            rdy        = dut_tready;
            tick();
            if (rdy) k++;
            cyc++;
        end
        dut_tvalid = 1'b0;
        check("pre_rst_beat_cnt", 128'(beat_cnt), 128'(5));
        check("pre_rst_tready", 128'(dut_tready), 128'(1));
        #3;
        rst_core = 1'b1;
        #1;
        check("arst_beat_cnt", 128'(beat_cnt), 128'(0));
        check("arst_dut_tready", 128'(dut_tready), 128'(0));
        check("arst_exp_tready", 128'(exp_tready), 128'(1));
        check("arst_halted", 128'(halted), 128'(0));
        #1;
        rst_core = 1'b0;
        tick();
        tick();
        tick();
        check("arst_fifo_empty", 128'(dut_tready), 128'(0));
        check("arst_beat_hold", 128'(beat_cnt), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
